// File: rtl/fp_add_normalize.sv
// Post-add normalize and round stage of the single-precision FP adder.
// Normalizes one bit per cycle, rounds to nearest-even, and packs the IEEE-754 word with flags.
module fp_add_normalize #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [MAN_W+1:0]       mag,
  input  logic                   sign,
  input  logic [EXP_W-1:0]       exp_in,
  input  logic                   sticky_in,
  output logic                   busy,
  output logic                   valid,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   ovf,
  output logic                   uf,
  output logic                   zero
);

  localparam int MW   = MAN_W + 2;
  localparam int EW   = EXP_W + 2;
  localparam int RW   = 1 + EXP_W + MAN_W;
  localparam int EMAX = (1 << EXP_W) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   busy_q;
  logic                   valid_q;
  logic [RW-1:0]          result_q;
  logic                   ovf_q;
  logic                   uf_q;
  logic                   zero_q;
  logic [MW-1:0]          m_q;
  logic signed [EW-1:0]   e_q;
  logic                   r_q;
  logic                   st_q;
  logic                   s_q;

  logic [MW-1:0]          m_sum_d;
  logic [MW-1:0]          m_rnd_d;
  logic signed [EW-1:0]   e_rnd_d;
  logic                   ovf_rnd_d;

  // Round-to-nearest-even increment: round bit set and either sticky or an odd LSB.
  function automatic logic [MW-1:0] rne_add(input logic [MW-1:0] m,
                                            input logic          r,
                                            input logic          st);
    logic inc;
    inc = r & (st | m[0]);
    return m + {{(MW-1){1'b0}}, inc};
  endfunction

  // Saturates to signed infinity when the exponent has left the finite range.
  function automatic logic [RW-1:0] pack_sat(input logic               s,
                                             input logic               sat,
                                             input logic [EXP_W-1:0]   e,
                                             input logic [MAN_W-1:0]   frac);
    if (sat) begin
      return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
    return {s, e, frac};
  endfunction

  always_comb begin
    m_sum_d = rne_add(m_q, r_q, st_q);
    m_rnd_d = m_sum_d;
    e_rnd_d = e_q;
    if (m_sum_d[MW-1]) begin
      m_rnd_d = m_sum_d >> 1;
      e_rnd_d = e_q + EW'(1);
    end
    ovf_rnd_d = (e_rnd_d >= EW'(EMAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      uf_q     <= 1'b0;
      zero_q   <= 1'b0;
      m_q      <= '0;
      e_q      <= '0;
      r_q      <= 1'b0;
      st_q     <= 1'b0;
      s_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        // Capture operands; flags and result from the previous operation are cleared here.
        IDLE: begin
          if (start) begin
            m_q      <= mag;
            e_q      <= signed'({{2{1'b0}}, exp_in});
            r_q      <= 1'b0;
            st_q     <= sticky_in;
            s_q      <= sign;
            result_q <= '0;
            ovf_q    <= 1'b0;
            uf_q     <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= NORM;
          end
        end
        // One normalization step per cycle; e never drops below 1, so uf fires at e==1.
        NORM: begin
          if (m_q == '0) begin
            zero_q   <= 1'b1;
            result_q <= {s_q, {(RW-1){1'b0}}};
            state_q  <= OUT;
          end else if (m_q[MW-1]) begin
            m_q     <= m_q >> 1;
            r_q     <= m_q[0];
            st_q    <= st_q | r_q;
            e_q     <= e_q + EW'(1);
            state_q <= ROUND;
          end else if (m_q[MW-2]) begin
            state_q <= ROUND;
          end else if (e_q == EW'(1)) begin
            uf_q     <= 1'b1;
            result_q <= {s_q, {(RW-1){1'b0}}};
            state_q  <= OUT;
          end else begin
            m_q <= {m_q[MW-2:0], r_q};
            r_q <= 1'b0;
            e_q <= e_q - EW'(1);
          end
        end
        // Round and pack.
        ROUND: begin
          m_q      <= m_rnd_d;
          e_q      <= e_rnd_d;
          ovf_q    <= ovf_rnd_d;
          result_q <= pack_sat(s_q, ovf_rnd_d, e_rnd_d[EXP_W-1:0], m_rnd_d[MAN_W-1:0]);
          state_q  <= OUT;
        end
        // Emit the one-cycle valid pulse as the machine returns to IDLE.
        OUT: begin
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign uf     = uf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_fp_add_normalize.sv
// Scoreboard bench for fp_add_normalize: directed corner cases plus random operands
// checked against a value-level reference of normalize, round-to-nearest-even and packing.
module tb_fp_add_normalize;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [24:0] mag = '0;
  logic        sign = 1'b0;
  logic [7:0]  exp_in = '0;
  logic        sticky_in = 1'b0;
  logic        busy, valid, ovf, uf, zero;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    bit          ovf;
    bit          uf;
    bit          zero;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   nvalid = 0;
  int   cyc = 0;

  fp_add_normalize #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mag(mag), .sign(sign),
    .exp_in(exp_in), .sticky_in(sticky_in), .busy(busy), .valid(valid),
    .result(result), .ovf(ovf), .uf(uf), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endfunction

  // Reference: treat mag as an integer significand, find its leading one, and derive
  // the normalized exponent, rounding and flags directly; due holds the latency.
  function automatic exp_t model(input logic [24:0] m, input bit s, input int ex, input bit sti);
    exp_t   x;
    int     p, e, k;
    longint sig;
    x.res = '0; x.ovf = 0; x.uf = 0; x.zero = 0; x.due = 0;
    if (m == 0) begin
      x.res = {s, 31'b0}; x.zero = 1; x.due = 2;
      return x;
    end
    p = 0;
    for (int i = 0; i < 25; i++) if (m[i]) p = i;
    if (p == 24) begin
      sig = longint'(m) / 2;
      e   = ex + 1;
      if (m[0] && (sti || (sig % 2 == 1))) sig = sig + 1;
      if (sig >= (longint'(1) << 24)) begin
        sig = sig / 2;
        e   = e + 1;
      end
      x.due = 3;
      if (e >= 255) begin
        x.ovf = 1; x.res = {s, 8'hFF, 23'b0};
      end else begin
        x.res = {s, 8'(e), 23'(sig)};
      end
    end else begin
      k = 23 - p;
      if (ex - k < 1) begin
        x.uf = 1; x.res = {s, 31'b0}; x.due = ex + 1;
      end else begin
        sig   = longint'(m) << k;
        x.res = {s, 8'(ex - k), 23'(sig)};
        x.due = 3 + k;
      end
    end
    return x;
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (rst_n && valid) begin
      nvalid++;
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        x = sb.pop_front();
        check("result", result, x.res);
        check("flags", {ovf, uf, zero}, {x.ovf, x.uf, x.zero});
        check("latency", cyc, x.due);
      end
    end
  end

  task automatic issue(input logic [24:0] m, input bit s, input int ex, input bit sti);
    exp_t x;
    int   n;
    n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      check("busy_timeout", 1, 0);
      return;
    end
    mag = m; sign = s; exp_in = 8'(ex); sticky_in = sti; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    x = model(m, s, ex, sti);
    x.due = cyc + x.due;
    sb.push_back(x);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    int          n0, bz, p, ex;
    logic [24:0] m;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {ovf, uf, zero}, 3'b000);
    rst_n = 1'b1;

    issue(25'h0800000, 0, 127, 0);
    issue(25'h1000000, 0, 127, 0);
    issue(25'h0000001, 0, 127, 0);
    bz = 1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (!busy) bz = 0;
    end
    check("busy_held", bz, 1);
    issue(25'h1800001, 0, 127, 0);
    issue(25'h1800001, 0, 127, 1);
    issue(25'h1000000, 0, 254, 0);
    issue(25'h1FFFFFF, 1, 253, 0);
    issue(25'h0000000, 1, 127, 0);
    issue(25'h0000001, 0, 5, 0);
    issue(25'h0400000, 1, 2, 0);
    issue(25'h0400000, 0, 1, 1);
    drain();

    for (int t = 0; t < 150; t++) begin
      p = $urandom_range(0, 30);
      if (p > 25) p = 24 - (p % 2);
      if (p == 25) m = '0;
      else begin
        m = 25'($urandom) & ((25'd1 << p) - 25'd1);
        m[p] = 1'b1;
      end
      ex = ($urandom_range(0, 3) == 0) ? $urandom_range(245, 254) : $urandom_range(1, 254);
      if ($urandom_range(0, 7) == 0) ex = $urandom_range(1, 24);
      issue(m, 1'($urandom), ex, 1'($urandom));
    end
    drain();

    n0 = nvalid;
    issue(25'h0000010, 0, 100, 0);
    @(negedge clk);
    mag = 25'h1000000; exp_in = 8'd10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    drain();
    check("ignored_start", nvalid - n0, 1);

    issue(25'h0000001, 0, 127, 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    sb.delete();
    n0 = nvalid;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_valid_after_abort", nvalid - n0, 0);

    issue(25'h0C00000, 1, 130, 0);
    drain();
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_add_normalize.md
Name: fp_add_normalize

Overview:
- Post-add normalize/round stage of the single-precision FP adder.
- Consumes the 25-bit magnitude and sign produced by the add/subtract stage, plus the larger-operand exponent and alignment sticky bit from the align stage.
- Normalizes iteratively, one bit per cycle, then rounds to nearest-even.
- Packs an IEEE-754 single with overflow, underflow and zero flags.

Parameters:
- EXP_W, 8: exponent width.
- MAN_W, 23: stored fraction width. The magnitude input is MAN_W+2 bits wide.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mag  in  25  unsigned magnitude. Bit 24 = carry, bit 23 = hidden-one position, bits 22:0 = fraction.
- sign  in  1  result sign.
- exp_in  in  8  biased exponent of the larger operand; legal range 1..254.
- sticky_in  in  1  OR of all bits discarded during alignment.
- busy  out  1  high in every state except IDLE.
- valid  out  1  one-cycle pulse; result and flags are valid while it is high.
- result  out  32  {sign, exponent[7:0], fraction[22:0]}.
- ovf  out  1  result overflowed to infinity.
- uf  out  1  result flushed to zero because it is below the normal range.
- zero  out  1  exact-zero magnitude.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, valid, result, ovf, uf, zero all 0; internal m, e, r, st cleared.
- A reset asserted mid-operation aborts the operation; no valid pulse is produced.
- Internal registers: m[24:0], e[9:0] (signed, guards wrap), r (round bit), st (sticky), s (sign).
- IDLE, on start: m=mag, e=exp_in, r=0, st=sticky_in, s=sign; go NORM. start while busy is ignored and not queued.
- NORM, evaluated each cycle in this priority order:
  - m==0: zero=1, result={s,31'b0}; go OUT.
  - m[24]=1: m=m>>1, r=m[0], st=st|r, e=e+1; go ROUND.
  - m[23]=1: go ROUND.
  - e==1: uf=1, result={s,31'b0}; go OUT. This flushes to zero; denormals are not produced.
  - Otherwise: m={m[23:0],r}, r=0, e=e-1; stay in NORM.
- ROUND (round to nearest-even):
  - Increment when r & (st | m[0]).
  - If the increment carries into bit 24: m=m>>1, e=e+1.
  - If final e>=255: ovf=1, result={s,8'hFF,23'b0}.
  - Else result={s,e[7:0],m[22:0]}.
  - Go OUT.
- OUT: valid=1 for exactly this cycle; go IDLE.
- Flags and result are held until the next start, and cleared on entry to NORM.
- Latency: start sampled at edge T; valid is high in the cycle after edge T+3+k, where k = number of left shifts (0..23).
- Worst case: 26 cycles from start to valid, for a single-bit cancellation.
- Only one operation is in flight at a time.
- Upstream must hold start until busy=0 or drop the request; there is no backpressure on valid.

Test Plan:
- mag=24'h800000, exp_in=127, sign=0, sticky_in=0 -> result=32'h3F800000, valid 3 cycles after start, all flags 0.
- mag=25'h1000000, exp_in=127 -> result=32'h40000000 (carry right-shift path), latency 3.
- mag=25'h0000001, exp_in=127 -> 23 left shifts, result=32'h34000000, valid at cycle 26, busy high throughout.
- mag=25'h1800001, exp_in=127:
  - sticky_in=0 (tie, even LSB) -> result=32'h40400000.
  - sticky_in=1 -> round up, result=32'h40400001.
- Boundaries:
  - mag=25'h1000000, exp_in=254 -> result=32'h7F800000, ovf=1.
  - mag=0, sign=1 -> result=32'h80000000, zero=1.
  - mag=25'h0000001, exp_in=5 -> result=0, uf=1.
- Control:
  - Second start pulse during busy -> ignored; exactly one valid pulse.
  - rst_n low in NORM -> busy=0 and valid=0 immediately; no valid pulse afterwards.
